fir_beat_packer: RTL and testbench

Source-side packer for the dual-channel FIR decimator input stream. It accepts one sample pair per cycle (channel 0 and channel 1) on a valid/ready input and assembles P_SAMPLES pairs into one wide beat, CHANNELS*P_SAMPLES*DATA_WIDTH bits. It presents that beat on an AXI-stream style master port that connects directly to the decimator's s_tvalid/s_tready/s_tdata. A one-beat output holding register lets assembly of the next beat overlap with downstream backpressure.

---
 rtl/fir_beat_packer.sv | 77 +++++++
 tb/tb_fir_beat_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_beat_packer.sv
// fir_beat_packer: packs dual-channel sample pairs into wide beats for the FIR decimator
module fir_beat_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int P_SAMPLES  = 8
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_WIDTH-1:0]                    in_ch0,
    input  logic [DATA_WIDTH-1:0]                    in_ch1,
    input  logic                                     flush,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] m_tdata,
    output logic [$clog2(P_SAMPLES)-1:0]             fill_level,
    output logic [15:0]                              beat_count
);
    localparam int CW = $clog2(P_SAMPLES);
    localparam logic [CW-1:0] LAST = CW'(P_SAMPLES - 1);
    typedef logic [P_SAMPLES-1:0][DATA_WIDTH-1:0] lanes_t;
    lanes_t asm0, asm1, sh0, sh1, beat0, beat1;
    logic [CW-1:0] cnt;
    logic [CW:0] n;
    logic pend, acc, comp, fl_req, emit;

    assign in_ready   = !pend && !(cnt == LAST && m_tvalid && !m_tready);
    assign acc        = in_valid && in_ready;
    assign comp       = acc && cnt == LAST;
    assign n          = {1'b0, cnt} + (CW+1)'(acc);
    assign fl_req     = (flush || pend) && (cnt != '0 || acc);
    assign emit       = comp || (fl_req && (!m_tvalid || m_tready));
    assign fill_level = cnt;

    // shift the new pair into lane 0 and zero lanes not written since the last beat
    always_comb begin
        sh0   = acc ? {asm0[P_SAMPLES-2:0], in_ch0} : asm0;
        sh1   = acc ? {asm1[P_SAMPLES-2:0], in_ch1} : asm1;
        beat0 = '0;
        beat1 = '0;
        for (int j = 0; j < P_SAMPLES; j++) begin
            beat0[j] = (j < int'(n)) ? sh0[j] : '0;
            beat1[j] = (j < int'(n)) ? sh1[j] : '0;
        end
    end

    // assembly lanes, fill counter and the pending-flush bit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            asm0 <= '0;
            asm1 <= '0;
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            asm0 <= sh0;
            asm1 <= sh1;
            cnt  <= emit ? '0 : n[CW-1:0];
            pend <= fl_req && !emit;
        end
    end

    // output holding register and handoff counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            beat_count <= '0;
        end else begin
            m_tvalid <= emit || (m_tvalid && !m_tready);
            if (emit)
                m_tdata <= {beat1, beat0};
            if (m_tvalid && m_tready)
                beat_count <= beat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fir_beat_packer.sv
// tb_fir_beat_packer: scoreboard bench for fir_beat_packer against a queue-based packing model
module tb_fir_beat_packer;
    localparam int DW = 16;
    localparam int P  = 8;
    localparam int BW = 2 * P * DW;

    logic clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, flush = 1'b0, m_tready = 1'b0;
    logic in_ready, m_tvalid;
    logic [DW-1:0] in_ch0 = '0, in_ch1 = '0;
    logic [BW-1:0] m_tdata;
    logic [2:0] fill_level;
    logic [15:0] beat_count;

    int n_checks = 0, n_fail = 0, stalls = 0, mon_beats = 0;
    logic [BW-1:0] exp_q[$];
    logic [DW-1:0] cur0[$], cur1[$];
    logic s_acc = 1'b0, s_flush = 1'b0;
    logic [DW-1:0] s_ch0, s_ch1;
    logic prev_hold = 1'b0;
    logic [BW-1:0] prev_data, held, e;

    fir_beat_packer #(.DATA_WIDTH(DW), .CHANNELS(2), .P_SAMPLES(P)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch0(in_ch0), .in_ch1(in_ch1), .flush(flush), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tdata(m_tdata), .fill_level(fill_level),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // beat expected from the pairs collected so far: newest pair in lane 0, unused lanes zero
    function automatic logic [BW-1:0] pack_cur();
        logic [BW-1:0] b = '0;
        int k = cur0.size();
        for (int j = 0; j < k; j++) begin
            b[j*DW +: DW]     = cur0[k-1-j];
            b[(P+j)*DW +: DW] = cur1[k-1-j];
        end
        return b;
    endfunction

    always @(negedge clk) begin
        s_acc   = nrst && in_valid && in_ready;
        s_flush = nrst && flush;
        s_ch0   = in_ch0;
        s_ch1   = in_ch1;
    end

    always @(posedge clk) begin
        if (nrst) begin
            if (s_acc) begin
                cur0.push_back(s_ch0);
                cur1.push_back(s_ch1);
            end
            if (cur0.size() == P || (s_flush && cur0.size() != 0)) begin
                exp_q.push_back(pack_cur());
                cur0.delete();
                cur1.delete();
            end
        end
    end

    always @(negedge nrst) begin
        exp_q.delete();
        cur0.delete();
        cur1.delete();
        prev_hold = 1'b0;
        mon_beats = 0;
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (prev_hold)
                check("hold_stable", m_tdata, prev_data);
            if (m_tvalid && m_tready) begin
                mon_beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got %0h expected none", m_tdata);
                end else
                    check("beat_data", m_tdata, exp_q.pop_front());
            end
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
        end
    end

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int i;
        in_valid = 1'b1;
        in_ch0   = a;
        in_ch1   = b;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i == 0) stalls++;
        end
        if (i == 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(posedge clk);
        #1;
        check("drain_empty", BW'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run got stuck expected finish");
        $fatal(1);
    end

    initial begin
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", BW'(m_tvalid), '0);
        check("rst_tdata", m_tdata, '0);
        check("rst_fill", BW'(fill_level), '0);
        check("rst_count", BW'(beat_count), '0);
        check("rst_ready", BW'(in_ready), 1);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++)
            send(DW'(i), DW'(16'h0100 + i));
        check("basic_tvalid", BW'(m_tvalid), 1);
        check("basic_l0_ch0", BW'(m_tdata[15:0]), 16'h0008);
        check("basic_l7_ch0", BW'(m_tdata[127:112]), 16'h0001);
        check("basic_l0_ch1", BW'(m_tdata[143:128]), 16'h0108);
        check("basic_fill", BW'(fill_level), '0);
        @(posedge clk);
        #1;
        check("basic_tvalid_drop", BW'(m_tvalid), '0);
        check("basic_count", BW'(beat_count), 1);
        stalls = 0;
        for (int i = 0; i < 64; i++)
            send(DW'($urandom), DW'($urandom));
        check("stream_stalls", BW'(stalls), '0);
        @(posedge clk);
        #1;
        check("stream_count", BW'(beat_count), 9);
        m_tready = 1'b0;
        for (int i = 0; i < 15; i++)
            send(DW'(16'h0200 + i), DW'(16'h0300 + i));
        check("bp_ready_low", BW'(in_ready), '0);
        check("bp_fill", BW'(fill_level), 7);
        check("bp_tvalid", BW'(m_tvalid), 1);
        held = m_tdata;
        check("bp_l0_ch0", BW'(held[15:0]), 16'h0207);
        repeat (3) @(posedge clk);
        #1;
        check("bp_held", m_tdata, held);
        m_tready = 1'b1;
        send(16'h020F, 16'h030F);
        check("sim_tvalid", BW'(m_tvalid), 1);
        check("sim_l0_ch0", BW'(m_tdata[15:0]), 16'h020F);
        check("sim_count", BW'(beat_count), 10);
        drain();
        check("bp_count", BW'(beat_count), 11);
        send(16'h000A, 16'h010A);
        send(16'h000B, 16'h010B);
        send(16'h000C, 16'h010C);
        pulse_flush();
        e = '0;
        e[15:0]    = 16'h000C;
        e[31:16]   = 16'h000B;
        e[47:32]   = 16'h000A;
        e[143:128] = 16'h010C;
        e[159:144] = 16'h010B;
        e[175:160] = 16'h010A;
        check("flush_tvalid", BW'(m_tvalid), 1);
        check("flush_beat", m_tdata, e);
        check("flush_fill", BW'(fill_level), '0);
        drain();
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(DW'(16'h0400 + i), DW'(16'h0410 + i));
        for (int i = 0; i < 3; i++)
            send(DW'(16'h0500 + i), DW'(16'h0510 + i));
        pulse_flush();
        check("pend_ready", BW'(in_ready), '0);
        check("pend_fill", BW'(fill_level), 3);
        @(posedge clk);
        #1;
        check("pend_ready_hold", BW'(in_ready), '0);
        drain();
        check("pend_ready_after", BW'(in_ready), 1);
        check("pend_fill_after", BW'(fill_level), '0);
        m_tready = 1'b0;
        for (int i = 0; i < 13; i++)
            send(DW'(16'h0600 + i), DW'(16'h0610 + i));
        check("arst_pre_fill", BW'(fill_level), 5);
        check("arst_pre_tvalid", BW'(m_tvalid), 1);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_tvalid", BW'(m_tvalid), '0);
        check("arst_tdata", m_tdata, '0);
        check("arst_fill", BW'(fill_level), '0);
        check("arst_count", BW'(beat_count), '0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        check("arst_ready", BW'(in_ready), 1);
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++)
            send(DW'(16'h0700 + i), DW'(16'h0710 + i));
        drain();
        check("arst_count_after", BW'(beat_count), 1);
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_ch0   = DW'($urandom);
            in_ch1   = DW'($urandom);
            flush    = ($urandom % 10) == 0;
            m_tready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        check("final_count", BW'(beat_count), BW'(mon_beats[15:0]));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
